// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the wrr_arbiter.
// master drives req/weight/done; slave (arbiter) drives grant outputs.
interface wrr_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = $clog2(NUM_PORTS)
) ();

  logic [NUM_PORTS-1:0]          req_i;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;
  logic                          done_i;
  logic [NUM_PORTS-1:0]          gnt_o;
  logic                          gnt_valid_o;
  logic [ID_W-1:0]               gnt_id_o;

  modport master (
    output req_i,
    output weight_i,
    output done_i,
    input  gnt_o,
    input  gnt_valid_o,
    input  gnt_id_o
  );

  modport slave (
    input  req_i,
    input  weight_i,
    input  done_i,
    output gnt_o,
    output gnt_valid_o,
    output gnt_id_o
  );

endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for
// max(weight,1) done pulses, zero-bubble hand-over between owners.
// Ports: clk, reset (async, active-high), bus (wrr_arbiter_if.slave):
//   req_i, weight_i, done_i in; gnt_o, gnt_valid_o, gnt_id_o out.
module wrr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input logic         clk,
  input logic         reset,
  wrr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;

  logic [WEIGHT_W-1:0]   wt [NUM_PORTS];
  logic [ID_W-1:0]       ptr_rel;
  pick_t                 sel_idle;
  pick_t                 sel_rel;
  logic                  own_req;
  logic                  rel;

  // Circular search from start; start has highest priority.
  function automatic pick_t pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [ID_W-1:0]      start
  );
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(start) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = ID_W'(j);
      end
    end
    return r;
  endfunction

  // Weight 0 behaves as weight 1.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      wt[p] = bus.weight_i[p*WEIGHT_W +: WEIGHT_W];
      if (wt[p] == '0) wt[p] = WEIGHT_W'(1);
    end
  end

  always_comb begin
    ptr_rel = owner_q + 1'b1;
    if (owner_q == ID_W'(NUM_PORTS - 1)) ptr_rel = '0;
  end

  assign sel_idle = pick(bus.req_i, ptr_q);
  assign sel_rel  = pick(bus.req_i, ptr_rel);
  assign own_req  = bus.req_i[owner_q];

  // Credit never sits at 0 in GRANT; <= guards it anyway.
  assign rel = !own_req ||
               (bus.done_i && credit_q <= WEIGHT_W'(1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (sel_idle.found) begin
          state_d  = GRANT;
          owner_d  = sel_idle.idx;
          credit_d = wt[sel_idle.idx];
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = ptr_rel;
          if (sel_rel.found) begin
            owner_d  = sel_rel.idx;
            credit_d = wt[sel_rel.idx];
          end else begin
            state_d  = IDLE;
            owner_d  = '0;
            credit_d = '0;
          end
        end else if (bus.done_i) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      gnt_q    <= gnt_d;
    end
  end

  // owner is cleared on entry to IDLE, so it doubles as the ID.
  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = |gnt_q;
  assign bus.gnt_id_o    = owner_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: directed req/done vectors push
// the expected grant; a monitor pops and compares after each edge.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic clk;
  logic reset;

  wrr_arbiter_if #(.NUM_PORTS(N), .WEIGHT_W(WW)) bus ();

  wrr_arbiter #(.NUM_PORTS(N), .WEIGHT_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [N-1:0] exp_q [$];
  int n_vec;
  int n_bad;
  int tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] id_of(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check(input logic [N-1:0] e, input string nm);
    logic [IW-1:0] eid;
    logic          ev;
    eid = id_of(e);
    ev  = |e;
    n_vec++;
    if (bus.gnt_o !== e || bus.gnt_valid_o !== ev ||
        bus.gnt_id_o !== eid) begin
      n_bad++;
      $display("FAIL %s: gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
               nm, bus.gnt_o, bus.gnt_valid_o, bus.gnt_id_o, e, ev, eid);
    end
  endtask

  // Monitor: grant outputs are presented every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(exp_q.pop_front(), $sformatf("vec%0d", tag));
        tag++;
      end
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic d,
                     input logic [N-1:0] e);
    bus.req_i  = r;
    bus.done_i = d;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_w(input int w0, input int w1,
                       input int w2, input int w3);
    bus.weight_i = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  task automatic do_reset();
    bus.req_i  = '0;
    bus.done_i = 1'b0;
    reset = 1'b1;
    #1;
    check('0, "reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, want finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    tag   = 0;
    reset = 1'b1;
    bus.req_i    = '0;
    bus.done_i   = 1'b0;
    set_w(1, 1, 1, 1);
    @(negedge clk);
    do_reset();

    // Plain rotation, weights 1.
    cyc(4'b1111, 1'b0, 4'b0001);
    cyc(4'b1111, 1'b1, 4'b0010);
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b1000);
    cyc(4'b1111, 1'b1, 4'b0001);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Weights 1,2,3,1: ports 0,1,1,2,2,2,3,0.
    do_reset();
    set_w(1, 2, 3, 1);
    cyc(4'b1111, 1'b0, 4'b0001);
    cyc(4'b1111, 1'b1, 4'b0010);
    cyc(4'b1111, 1'b1, 4'b0010);
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b1000);
    cyc(4'b1111, 1'b1, 4'b0001);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Sole requester port 2, weight 0: back-to-back regrant.
    do_reset();
    set_w(1, 1, 0, 1);
    cyc(4'b0100, 1'b0, 4'b0100);
    cyc(4'b0100, 1'b1, 4'b0100);
    cyc(4'b0100, 1'b1, 4'b0100);
    cyc(4'b0100, 1'b1, 4'b0100);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Port 1 weight 4 aborts after one done; port 3 takes over.
    do_reset();
    set_w(1, 4, 1, 1);
    cyc(4'b1010, 1'b0, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b0010);
    cyc(4'b1000, 1'b0, 4'b1000);
    cyc(4'b1000, 1'b1, 4'b1000);
    cyc(4'b0000, 1'b0, 4'b0000);

    // done ignored while idle, then 0110 request.
    set_w(1, 1, 1, 1);
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0110, 1'b0, 4'b0010);
    cyc(4'b0110, 1'b1, 4'b0100);
    cyc(4'b0110, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Async reset mid-burst on port 3.
    do_reset();
    set_w(1, 1, 1, 4);
    cyc(4'b1000, 1'b0, 4'b1000);
    cyc(4'b1000, 1'b1, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    check('0, "async_reset");
    @(negedge clk);
    reset = 1'b0;
    cyc(4'b1001, 1'b0, 4'b0001);
    cyc(4'b1001, 1'b1, 4'b1000);
    // done together with req drop is a release.
    cyc(4'b0001, 1'b1, 4'b0001);
    cyc(4'b0000, 1'b0, 4'b0000);

    // Weight lowered mid-grant keeps the loaded credit of 3.
    do_reset();
    set_w(3, 1, 1, 1);
    cyc(4'b0011, 1'b0, 4'b0001);
    set_w(1, 1, 1, 1);
    cyc(4'b0011, 1'b1, 4'b0001);
    cyc(4'b0011, 1'b1, 4'b0001);
    cyc(4'b0011, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b0, 4'b0000);

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
